// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: sync/DE/counters/field for any mode
// described at runtime, advancing on a pixel clock-enable.
module video_timing_gen #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 11
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    input  logic [H_BITS-1:0] H_TOTAL,
    input  logic [H_BITS-1:0] H_ACTIVE,
    input  logic [H_BITS-1:0] H_SYNC_START,
    input  logic [H_BITS-1:0] H_SYNC_END,
    input  logic [V_BITS-1:0] V_TOTAL,
    input  logic [V_BITS-1:0] V_ACTIVE,
    input  logic [V_BITS-1:0] V_SYNC_START,
    input  logic [V_BITS-1:0] V_SYNC_END,
    input  logic              INTERLACE,
    output logic [H_BITS-1:0] HCNT,
    output logic [V_BITS-1:0] VCNT,
    output logic              HS_n,
    output logic              VS_n,
    output logic              DE,
    output logic              FIELD,
    output logic              LINE_START,
    output logic              FRAME_START
);

    // Shadow copy of the timing, stable for a whole frame
    logic              r_primed;
    logic [H_BITS-1:0] r_ht;
    logic [H_BITS-1:0] r_ha;
    logic [H_BITS-1:0] r_hss;
    logic [H_BITS-1:0] r_hse;
    logic [V_BITS-1:0] r_vt;
    logic [V_BITS-1:0] r_va;
    logic [V_BITS-1:0] r_vss;
    logic [V_BITS-1:0] r_vse;
    logic              r_il;

    logic [H_BITS-1:0] r_hcnt;
    logic [V_BITS-1:0] r_vcnt;
    logic              r_field;
    logic              r_hs_n;
    logic              r_vs_n;
    logic              r_de;
    logic              r_line_start;
    logic              r_frame_start;

    logic [H_BITS-1:0] w_in_ht;
    logic [V_BITS-1:0] w_in_vt;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_frame_wrap;
    logic              w_load;

    logic [H_BITS-1:0] w_next_h;
    logic [V_BITS-1:0] w_next_v;
    logic              w_next_field;

    logic [H_BITS-1:0] w_e_ht;
    logic [H_BITS-1:0] w_e_ha;
    logic [H_BITS-1:0] w_e_hss;
    logic [H_BITS-1:0] w_e_hse;
    logic [V_BITS-1:0] w_e_va;
    logic [V_BITS-1:0] w_e_vss;
    logic [V_BITS-1:0] w_e_vse;
    logic              w_e_il;

    logic [H_BITS-1:0] w_half;
    logic              w_hs_act;
    logic              w_vs_full;
    logic              w_vs_half;
    logic              w_vs_act;
    logic              w_de;

    always_comb begin
        w_in_ht      = (H_TOTAL < H_BITS'(2)) ? H_BITS'(2) : H_TOTAL;
        w_in_vt      = (V_TOTAL == '0) ? V_BITS'(1) : V_TOTAL;
        w_h_last     = (r_hcnt == r_ht - H_BITS'(1));
        w_v_last     = (r_vcnt == r_vt - V_BITS'(1));
        w_frame_wrap = w_h_last && w_v_last;
        w_load       = !r_primed || w_frame_wrap;
    end

    // Before the first CE the raster starts at (0,0) in field 0
    always_comb begin
        w_next_h     = '0;
        w_next_v     = '0;
        w_next_field = 1'b0;
        if (r_primed) begin
            w_next_h     = w_h_last ? '0 : r_hcnt + H_BITS'(1);
            w_next_v     = r_vcnt;
            w_next_field = r_field;
            if (w_h_last) begin
                w_next_v = w_v_last ? '0 : r_vcnt + V_BITS'(1);
            end
            if (w_frame_wrap) begin
                w_next_field = r_il ? ~r_field : 1'b0;
            end
        end
    end

    // Decode against the timing that will govern the next position: the
    // incoming inputs when a new frame is latched, else the shadow copy.
    always_comb begin
        w_e_ht  = r_ht;
        w_e_ha  = r_ha;
        w_e_hss = r_hss;
        w_e_hse = r_hse;
        w_e_va  = r_va;
        w_e_vss = r_vss;
        w_e_vse = r_vse;
        w_e_il  = r_il;
        if (w_load) begin
            w_e_ht  = w_in_ht;
            w_e_ha  = H_ACTIVE;
            w_e_hss = H_SYNC_START;
            w_e_hse = H_SYNC_END;
            w_e_va  = V_ACTIVE;
            w_e_vss = V_SYNC_START;
            w_e_vse = V_SYNC_END;
            w_e_il  = INTERLACE;
        end
    end

    always_comb begin
        w_half    = w_e_ht >> 1;
        w_hs_act  = (w_e_hss < w_e_hse) && (w_next_h >= w_e_hss) && (w_next_h < w_e_hse);
        w_vs_full = (w_e_vss < w_e_vse) && (w_next_v >= w_e_vss) && (w_next_v < w_e_vse);
        // Second interlaced field: VS spans (VSS, Ht/2) up to (VSE, Ht/2)
        w_vs_half = (w_e_vss < w_e_vse)
                 && ((w_next_v > w_e_vss) || ((w_next_v == w_e_vss) && (w_next_h >= w_half)))
                 && ((w_next_v < w_e_vse) || ((w_next_v == w_e_vse) && (w_next_h < w_half)));
        w_vs_act  = (w_next_field && w_e_il) ? w_vs_half : w_vs_full;
        w_de      = (w_next_h < w_e_ha) && (w_next_v < w_e_va);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_primed      <= 1'b0;
            r_ht          <= '0;
            r_ha          <= '0;
            r_hss         <= '0;
            r_hse         <= '0;
            r_vt          <= '0;
            r_va          <= '0;
            r_vss         <= '0;
            r_vse         <= '0;
            r_il          <= 1'b0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_field       <= 1'b0;
            r_hs_n        <= 1'b1;
            r_vs_n        <= 1'b1;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (CE) begin
            if (w_load) begin
                r_primed <= 1'b1;
                r_ht     <= w_in_ht;
                r_ha     <= H_ACTIVE;
                r_hss    <= H_SYNC_START;
                r_hse    <= H_SYNC_END;
                r_vt     <= w_in_vt;
                r_va     <= V_ACTIVE;
                r_vss    <= V_SYNC_START;
                r_vse    <= V_SYNC_END;
                r_il     <= INTERLACE;
            end
            r_hcnt        <= w_next_h;
            r_vcnt        <= w_next_v;
            r_field       <= w_next_field;
            r_hs_n        <= ~w_hs_act;
            r_vs_n        <= ~w_vs_act;
            r_de          <= w_de;
            r_line_start  <= (w_next_h == '0);
            r_frame_start <= (w_next_h == '0) && (w_next_v == '0);
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign HCNT        = r_hcnt;
    assign VCNT        = r_vcnt;
    assign HS_n        = r_hs_n;
    assign VS_n        = r_vs_n;
    assign DE          = r_de;
    assign FIELD       = r_field;
    assign LINE_START  = r_line_start;
    assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: basic raster, CE gating, interlace,
// shadowing, degenerate totals and mid-frame reset.
module tb_video_timing_gen;

    localparam int H_BITS = 12;
    localparam int V_BITS = 11;
    localparam int VW     = H_BITS + V_BITS + 6;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              CE = 1'b0;
    logic [H_BITS-1:0] H_TOTAL = '0;
    logic [H_BITS-1:0] H_ACTIVE = '0;
    logic [H_BITS-1:0] H_SYNC_START = '0;
    logic [H_BITS-1:0] H_SYNC_END = '0;
    logic [V_BITS-1:0] V_TOTAL = '0;
    logic [V_BITS-1:0] V_ACTIVE = '0;
    logic [V_BITS-1:0] V_SYNC_START = '0;
    logic [V_BITS-1:0] V_SYNC_END = '0;
    logic              INTERLACE = 1'b0;
    logic [H_BITS-1:0] HCNT;
    logic [V_BITS-1:0] VCNT;
    logic              HS_n;
    logic              VS_n;
    logic              DE;
    logic              FIELD;
    logic              LINE_START;
    logic              FRAME_START;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] got;
    assign got = {HCNT, VCNT, HS_n, VS_n, DE, FIELD, LINE_START, FRAME_START};

    video_timing_gen #(.H_BITS(H_BITS), .V_BITS(V_BITS)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
        .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
        .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE),
        .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END),
        .INTERLACE(INTERLACE),
        .HCNT(HCNT), .VCNT(VCNT), .HS_n(HS_n), .VS_n(VS_n), .DE(DE),
        .FIELD(FIELD), .LINE_START(LINE_START), .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    function automatic logic [VW-1:0] pack(input int h, input int v, input bit hs_n,
                                           input bit vs_n, input bit de, input bit field,
                                           input bit ls, input bit fs);
        return {H_BITS'(h), V_BITS'(v), hs_n, vs_n, de, field, ls, fs};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        CE    = 1'b0;
        step();
        RESET = 1'b0;
        step();
    endtask

    task automatic set_basic(input bit il);
        H_TOTAL      = 12'd10;
        H_ACTIVE     = 12'd6;
        H_SYNC_START = 12'd7;
        H_SYNC_END   = 12'd9;
        V_TOTAL      = 11'd5;
        V_ACTIVE     = 11'd3;
        V_SYNC_START = 11'd3;
        V_SYNC_END   = 11'd4;
        INTERLACE    = il;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp;
        set_basic(1'b0);
        RESET = 1'b1;
        CE    = 1'b1;
        step();
        exp = pack(0, 0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", got, exp);
        end
        CE    = 1'b0;
        RESET = 1'b0;
        step();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_hold_ce0 got %h exp %h", got, exp);
        end
        CE = 1'b1;
        step();
        exp = pack(0, 0, 1, 1, 1, 0, 1, 1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL first_ce got %h exp %h", got, exp);
        end
    endtask

    task automatic test_basic();
        logic [VW-1:0] exp;
        int eh = 0;
        int ev = 0;
        int last_fs = -1;
        do_reset();
        set_basic(1'b0);
        CE = 1'b1;
        step();
        for (int c = 0; c < 101; c++) begin
            if (c > 0) begin
                step();
                if (eh == 9) begin
                    eh = 0;
                    ev = (ev == 4) ? 0 : ev + 1;
                end else begin
                    eh++;
                end
            end
            exp = pack(eh, ev, !(eh >= 7 && eh < 9), !(ev == 3), (eh < 6 && ev < 3),
                       0, eh == 0, eh == 0 && ev == 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic c=%0d got %h exp %h", c, got, exp);
            end
            if (FRAME_START) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (c - last_fs != 50) begin
                        errors++;
                        $display("FAIL basic_frame_period got %0d exp 50", c - last_fs);
                    end
                end
                last_fs = c;
            end
        end
    endtask

    task automatic test_ce_gating();
        logic [VW-1:0] exp;
        bit primed = 0;
        bit ls;
        int eh = 0;
        int ev = 0;
        int last_fs = -1;
        int n_fs = 0;
        do_reset();
        set_basic(1'b0);
        for (int k = 0; k < 301; k++) begin
            CE = (k % 3 == 0);
            step();
            if (CE) begin
                if (!primed) begin
                    primed = 1;
                end else if (eh == 9) begin
                    eh = 0;
                    ev = (ev == 4) ? 0 : ev + 1;
                end else begin
                    eh++;
                end
            end
            ls = CE && (eh == 0);
            exp = pack(eh, ev, !(eh >= 7 && eh < 9), !(ev == 3), (eh < 6 && ev < 3),
                       0, ls, ls && ev == 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ce_gating k=%0d got %h exp %h", k, got, exp);
            end
            if (FRAME_START) begin
                n_fs++;
                if (last_fs >= 0) begin
                    checks++;
                    if (k - last_fs != 150) begin
                        errors++;
                        $display("FAIL ce_frame_period got %0d exp 150", k - last_fs);
                    end
                end
                last_fs = k;
            end
        end
        checks++;
        if (n_fs != 3) begin
            errors++;
            $display("FAIL ce_frame_count got %0d exp 3", n_fs);
        end
    endtask

    task automatic test_interlace();
        logic [VW-1:0] exp;
        bit ef = 0;
        bit vs_act;
        int eh = 0;
        int ev = 0;
        int n_fs = 0;
        bit fields[4];
        do_reset();
        set_basic(1'b1);
        CE = 1'b1;
        step();
        for (int c = 0; c < 200; c++) begin
            if (c > 0) begin
                step();
                if (eh == 9) begin
                    eh = 0;
                    if (ev == 4) begin
                        ev = 0;
                        ef = !ef;
                    end else begin
                        ev++;
                    end
                end else begin
                    eh++;
                end
            end
            if (ef) vs_act = (ev == 3 && eh >= 5) || (ev == 4 && eh < 5);
            else    vs_act = (ev == 3);
            exp = pack(eh, ev, !(eh >= 7 && eh < 9), !vs_act, (eh < 6 && ev < 3),
                       ef, eh == 0, eh == 0 && ev == 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL interlace c=%0d got %h exp %h", c, got, exp);
            end
            if (FRAME_START && n_fs < 4) begin
                fields[n_fs] = FIELD;
                n_fs++;
            end
        end
        checks++;
        if (n_fs != 4 || fields[0] !== 1'b0 || fields[1] !== 1'b1 ||
            fields[2] !== 1'b0 || fields[3] !== 1'b1) begin
            errors++;
            $display("FAIL field_sequence got n=%0d %b%b%b%b exp 4 0101",
                     n_fs, fields[0], fields[1], fields[2], fields[3]);
        end
    endtask

    task automatic test_shadow();
        logic [VW-1:0] exp;
        int eh = 0;
        int ev = 0;
        int cur_ht = 10;
        int new_ht = 10;
        int fs_at[$];
        do_reset();
        set_basic(1'b0);
        CE = 1'b1;
        step();
        for (int c = 0; c < 160; c++) begin
            if (c > 0) begin
                step();
                if (eh == cur_ht - 1) begin
                    eh = 0;
                    if (ev == 4) begin
                        ev = 0;
                        cur_ht = new_ht;
                    end else begin
                        ev++;
                    end
                end else begin
                    eh++;
                end
            end
            exp = pack(eh, ev, !(eh >= 7 && eh < 9), !(ev == 3), (eh < 6 && ev < 3),
                       0, eh == 0, eh == 0 && ev == 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL shadow c=%0d got %h exp %h", c, got, exp);
            end
            if (FRAME_START) fs_at.push_back(c);
            if (c == 20) begin
                H_TOTAL = 12'd8;
                new_ht  = 8;
            end
        end
        checks++;
        if (fs_at.size() != 4 || fs_at[0] != 0 || fs_at[1] != 50 ||
            fs_at[2] != 90 || fs_at[3] != 130) begin
            errors++;
            $display("FAIL shadow_frame_starts got n=%0d exp 0,50,90,130", fs_at.size());
        end
    endtask

    task automatic test_degenerate();
        logic [VW-1:0] exp;
        do_reset();
        set_basic(1'b0);
        H_TOTAL      = 12'd0;
        V_TOTAL      = 11'd0;
        H_SYNC_START = 12'd4;
        H_SYNC_END   = 12'd4;
        CE = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            exp = pack(c % 2, 0, 1, 1, 1, 0, c % 2 == 0, c % 2 == 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL degenerate c=%0d got %h exp %h", c, got, exp);
            end
        end
        do_reset();
        set_basic(1'b0);
        H_SYNC_START = 12'd8;
        H_SYNC_END   = 12'd3;
        CE = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (HS_n !== 1'b1) begin
                errors++;
                $display("FAIL hs_start_ge_end c=%0d got %b exp 1", c, HS_n);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] exp;
        do_reset();
        set_basic(1'b1);
        CE = 1'b1;
        step();
        for (int c = 0; c < 76; c++) step();
        exp = pack(6, 2, 1, 1, 0, 1, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL pre_reset_pos got %h exp %h", got, exp);
        end
        #2;
        RESET = 1'b1;
        #1;
        exp = pack(0, 0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", got, exp);
        end
        H_TOTAL = 12'd8;
        step();
        RESET = 1'b0;
        step();
        exp = pack(0, 0, 1, 1, 1, 0, 1, 1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL post_reset_first_ce got %h exp %h", got, exp);
        end
        for (int c = 0; c < 8; c++) step();
        exp = pack(0, 1, 1, 1, 1, 0, 1, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL post_reset_resample got %h exp %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ce_gating();
        test_interlace();
        test_shadow();
        test_degenerate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
